// File: rtl/piso_shift_reg_using_d_ff_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and the
// bit-counter width helper.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Counter must index 0..WIDTH-1 and stay at least one bit wide for WIDTH=1.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_shift_reg_using_d_ff_if.sv
// Parallel-in / serial-out bus of the PISO serializer.
// Handshakes: a parallel word transfers at a rising edge where in_valid && in_ready;
// a serial bit transfers at a rising edge where s_valid && s_ready. A producer holding
// valid may not assume transfer until it sees ready at that same edge.
interface piso_shift_reg_using_d_ff_if #(
    parameter int WIDTH = 4
);
    import piso_pkg::*;

    logic [WIDTH-1:0] p_in;
    logic             in_valid;
    logic             in_ready;
    logic             s_out;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;
    logic             busy;
    piso_state_t      dbg_state;

    modport slave (
        input  p_in, in_valid, s_ready,
        output in_ready, s_out, s_valid, s_last, busy, dbg_state
    );

    modport master (
        output p_in, in_valid, s_ready,
        input  in_ready, s_out, s_valid, s_last, busy, dbg_state
    );

endinterface

// File: rtl/d_ff_en.sv
// Single D flip-flop with asynchronous active-low reset and load enable;
// one bit cell of the serializer shift register.
module d_ff_en (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/piso_shift_reg_using_d_ff.sv
// Parallel-in serial-out stage: accepts a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per accepted serial cycle, with back-to-back reload.
module piso_shift_reg_using_d_ff
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    piso_shift_reg_using_d_ff_if.slave   bus
);

    localparam int             CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    piso_state_t      state;
    piso_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] shifted;
    logic             at_last;
    logic             in_ready_c;
    logic             load;
    logic             advance;
    logic             reg_en;

    // Next-state, counter and shift-register control.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        at_last    = (state == SHIFT) && (cnt == LAST);
        in_ready_c = (state == IDLE) || ((state == SHIFT) && bus.s_ready && at_last);
        load       = bus.in_valid && in_ready_c;
        advance    = (state == SHIFT) && bus.s_ready;
        reg_en     = load || advance;
        shifted    = MSB_FIRST ? (q << 1) : (q >> 1);
        d          = load ? bus.p_in : shifted;

        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (load) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end else if (advance && at_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (advance) begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Shift register built from individual enabled flops; s_out taps its end bit only.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_en u_ff (
            .clk   (clk),
            .rst_n (rst),
            .en    (reg_en),
            .d     (d[i]),
            .q     (q[i])
        );
    end

    assign bus.s_out     = MSB_FIRST ? q[WIDTH-1] : q[0];
    assign bus.s_valid   = (state == SHIFT);
    assign bus.busy      = (state == SHIFT);
    assign bus.s_last    = at_last;
    assign bus.in_ready  = in_ready_c;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_piso_shift_reg_using_d_ff.sv
// Directed bench for the PISO serializer: MSB-first and LSB-first WIDTH=4 builds
// plus a WIDTH=1 build, sharing clock and reset.
module tb_piso_shift_reg_using_d_ff;
  import piso_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  piso_shift_reg_using_d_ff_if #(.WIDTH(4)) bus_a ();
  piso_shift_reg_using_d_ff_if #(.WIDTH(4)) bus_b ();
  piso_shift_reg_using_d_ff_if #(.WIDTH(1)) bus_c ();

  piso_shift_reg_using_d_ff #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  piso_shift_reg_using_d_ff #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  piso_shift_reg_using_d_ff #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b0;
    bus_a.p_in = '0; bus_a.in_valid = 1'b0; bus_a.s_ready = 1'b1;
    bus_b.p_in = '0; bus_b.in_valid = 1'b0; bus_b.s_ready = 1'b1;
    bus_c.p_in = '0; bus_c.in_valid = 1'b0; bus_c.s_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_a.s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b want 0", bus_a.s_valid); end
    n_cmp++; if (bus_a.s_out !== 1'b0) begin n_fail++; $display("FAIL reset_s_out: got %b want 0", bus_a.s_out); end
    n_cmp++; if (bus_a.s_last !== 1'b0) begin n_fail++; $display("FAIL reset_s_last: got %b want 0", bus_a.s_last); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus_a.in_ready); end
    n_cmp++; if (bus_a.dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %b want IDLE", bus_a.dbg_state); end
  endtask

  // 1011 MSB-first; a stray word offered mid-shift must be ignored.
  task automatic test_single;
    logic [3:0] exp_s;
    exp_s = 4'b1011;
    @(negedge clk);
    bus_a.p_in = 4'b1011; bus_a.in_valid = 1'b1; bus_a.s_ready = 1'b1;
    #1;
    n_cmp++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept_ready: got %b want 1", bus_a.in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus_a.in_valid = 1'b0;
      if (k == 1) begin bus_a.in_valid = 1'b1; bus_a.p_in = 4'b0000; end
      if (k == 2) bus_a.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus_a.s_out !== exp_s[3-k]) begin n_fail++; $display("FAIL single_s_out[%0d]: got %b want %b", k, bus_a.s_out, exp_s[3-k]); end
      n_cmp++; if (bus_a.s_valid !== 1'b1) begin n_fail++; $display("FAIL single_s_valid[%0d]: got %b want 1", k, bus_a.s_valid); end
      n_cmp++; if (bus_a.s_last !== (k == 3)) begin n_fail++; $display("FAIL single_s_last[%0d]: got %b want %b", k, bus_a.s_last, (k == 3)); end
      n_cmp++; if (bus_a.in_ready !== (k == 3)) begin n_fail++; $display("FAIL single_in_ready[%0d]: got %b want %b", k, bus_a.in_ready, (k == 3)); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus_a.s_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_s_valid: got %b want 0", bus_a.s_valid); end
    n_cmp++; if (bus_a.dbg_state !== IDLE) begin n_fail++; $display("FAIL single_end_state: got %b want IDLE", bus_a.dbg_state); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_s;
    exp_s = 8'b1011_1111;
    @(negedge clk);
    bus_a.p_in = 4'b1011; bus_a.in_valid = 1'b1; bus_a.s_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) bus_a.p_in = 4'b1111;
      if (k == 4) bus_a.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus_a.s_out !== exp_s[7-k]) begin n_fail++; $display("FAIL b2b_s_out[%0d]: got %b want %b", k, bus_a.s_out, exp_s[7-k]); end
      n_cmp++; if (bus_a.s_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_s_valid[%0d]: got %b want 1", k, bus_a.s_valid); end
      n_cmp++; if (bus_a.s_last !== (k == 3 || k == 7)) begin n_fail++; $display("FAIL b2b_s_last[%0d]: got %b want %b", k, bus_a.s_last, (k == 3 || k == 7)); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus_a.s_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_s_valid: got %b want 0", bus_a.s_valid); end
  endtask

  // 0111 with s_ready low for three edges while bit 2 is shown.
  task automatic test_backpressure;
    logic [6:0] exp_s;
    exp_s = 7'b0111111;
    @(negedge clk);
    bus_a.p_in = 4'b0111; bus_a.in_valid = 1'b1; bus_a.s_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) bus_a.in_valid = 1'b0;
      bus_a.s_ready = !(k >= 1 && k <= 3);
      #1;
      n_cmp++; if (bus_a.s_out !== exp_s[6-k]) begin n_fail++; $display("FAIL bp_s_out[%0d]: got %b want %b", k, bus_a.s_out, exp_s[6-k]); end
      n_cmp++; if (bus_a.s_valid !== 1'b1) begin n_fail++; $display("FAIL bp_s_valid[%0d]: got %b want 1", k, bus_a.s_valid); end
      n_cmp++; if (bus_a.s_last !== (k == 6)) begin n_fail++; $display("FAIL bp_s_last[%0d]: got %b want %b", k, bus_a.s_last, (k == 6)); end
      if (k == 3) begin
        n_cmp++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stall: got %b want 0", bus_a.in_ready); end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus_a.s_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_s_valid: got %b want 0", bus_a.s_valid); end
  endtask

  task automatic test_reset_mid_word;
    logic [3:0] exp_s;
    exp_s = 4'b0001;
    @(negedge clk);
    bus_a.p_in = 4'b1101; bus_a.in_valid = 1'b1; bus_a.s_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus_a.in_valid = 1'b0;
    end
    // third bit now showing; reset between edges must clear outputs at once
    rst = 1'b0;
    #1;
    n_cmp++; if (bus_a.s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_s_valid: got %b want 0", bus_a.s_valid); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.s_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_s_last: got %b want 0", bus_a.s_last); end
    n_cmp++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", bus_a.in_ready); end
    n_cmp++; if (bus_a.s_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_s_out: got %b want 0", bus_a.s_out); end
    @(negedge clk);
    rst = 1'b1;
    bus_a.p_in = 4'b0001; bus_a.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus_a.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus_a.s_out !== exp_s[3-k]) begin n_fail++; $display("FAIL rst_next_s_out[%0d]: got %b want %b", k, bus_a.s_out, exp_s[3-k]); end
      n_cmp++; if (bus_a.s_valid !== 1'b1) begin n_fail++; $display("FAIL rst_next_s_valid[%0d]: got %b want 1", k, bus_a.s_valid); end
      n_cmp++; if (bus_a.s_last !== (k == 3)) begin n_fail++; $display("FAIL rst_next_s_last[%0d]: got %b want %b", k, bus_a.s_last, (k == 3)); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus_a.s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_next_end_s_valid: got %b want 0", bus_a.s_valid); end
  endtask

  task automatic test_lsb_first;
    logic [3:0] exp_s;
    exp_s = 4'b1101;
    @(negedge clk);
    bus_b.p_in = 4'b1101; bus_b.in_valid = 1'b1; bus_b.s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus_b.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus_b.s_out !== exp_s[k]) begin n_fail++; $display("FAIL lsb_s_out[%0d]: got %b want %b", k, bus_b.s_out, exp_s[k]); end
      n_cmp++; if (bus_b.s_last !== (k == 3)) begin n_fail++; $display("FAIL lsb_s_last[%0d]: got %b want %b", k, bus_b.s_last, (k == 3)); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus_b.s_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_end_s_valid: got %b want 0", bus_b.s_valid); end
  endtask

  task automatic test_width1;
    @(negedge clk);
    bus_c.p_in = 1'b1; bus_c.in_valid = 1'b1; bus_c.s_ready = 1'b1;
    @(negedge clk);
    bus_c.in_valid = 1'b0;
    bus_c.s_ready  = 1'b0;
    #1;
    n_cmp++; if (bus_c.s_out !== 1'b1) begin n_fail++; $display("FAIL w1_s_out: got %b want 1", bus_c.s_out); end
    n_cmp++; if (bus_c.s_valid !== 1'b1) begin n_fail++; $display("FAIL w1_s_valid: got %b want 1", bus_c.s_valid); end
    n_cmp++; if (bus_c.s_last !== 1'b1) begin n_fail++; $display("FAIL w1_s_last: got %b want 1", bus_c.s_last); end
    n_cmp++; if (bus_c.in_ready !== 1'b0) begin n_fail++; $display("FAIL w1_in_ready_stall: got %b want 0", bus_c.in_ready); end
    @(negedge clk);
    bus_c.s_ready = 1'b1;
    #1;
    n_cmp++; if (bus_c.s_out !== 1'b1) begin n_fail++; $display("FAIL w1_hold_s_out: got %b want 1", bus_c.s_out); end
    n_cmp++; if (bus_c.in_ready !== 1'b1) begin n_fail++; $display("FAIL w1_in_ready: got %b want 1", bus_c.in_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus_c.s_valid !== 1'b0) begin n_fail++; $display("FAIL w1_end_s_valid: got %b want 0", bus_c.s_valid); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_lsb_first();
    test_width1();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
